// File: rtl/apu_aout_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : apu_aout_sequencer_pkg
// Purpose : Shared audio-out parameters (oversample ratio, sample width and
//           fractional-divider widths) plus small helpers used by the
//           sequencer and its clock divider. The 16x filter uses the same
//           values.
// Revision: 1.0 - initial release
// ============================================================================
package apu_aout_sequencer_pkg;

    localparam int OSR      = 16;            // ticks per input sample, power of 2
    localparam int W_SAMPLE = 16;            // signed sample width
    localparam int W_DINT   = 8;             // divider integer width
    localparam int W_DFRAC  = 8;             // divider fractional width
    localparam int W_PHASE  = $clog2(OSR);   // oversample phase width

    typedef logic signed [W_SAMPLE-1:0] sample_t;

    // The counter needs at least two clocks per tick so that strobes can
    // never land on consecutive cycles; 0 and 1 are promoted to 2.
    function automatic logic [W_DINT-1:0] div_int_eff(input logic [W_DINT-1:0] d);
        return (d < W_DINT'(2)) ? W_DINT'(2) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apu_aout_sequencer_frac_clkdiv.sv
`default_nettype none
// ============================================================================
// Module  : apu_frac_clkdiv
// Purpose : Fractional clock divider producing the oversample tick.
//           Mean tick period = div_int + div_frac/2^W_DFRAC clocks.
// Ports   : clk, rst_n      - clock, async active-low reset
//           en              - run enable; low returns counter/accumulator to 0
//           div_int         - integer clocks per tick (0/1 act as 2)
//           div_frac        - fractional clocks per tick
//           tick            - one-cycle tick strobe
// Revision: 1.0 - initial release
// ============================================================================
module apu_frac_clkdiv
    import apu_aout_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [W_DINT-1:0]  div_int,
    input  logic [W_DFRAC-1:0] div_frac,
    output logic               tick
);

    logic [W_DINT-1:0]  r_cnt;
    logic [W_DFRAC-1:0] r_facc;
    logic [W_DFRAC:0]   w_sum;
    logic [W_DINT-1:0]  w_reload;

    // A zero counter while enabled is a tick, so the first tick lands on the
    // very first enabled cycle.
    assign tick  = en && (r_cnt == '0);
    assign w_sum = {1'b0, r_facc} + {1'b0, div_frac};

    // Interval is max(int,2) plus the accumulator carry; the counter holds
    // interval-1 because the tick cycle itself is the first clock of it.
    // Effective int >= 2 keeps this from underflowing, and 255-1+1 fits.
    assign w_reload = div_int_eff(div_int) - W_DINT'(1) + W_DINT'(w_sum[W_DFRAC]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_facc <= '0;
        end else if (!en) begin
            r_cnt  <= '0;
            r_facc <= '0;
        end else if (tick) begin
            r_cnt  <= w_reload;
            r_facc <= w_sum[W_DFRAC-1:0];
        end else begin
            r_cnt  <= r_cnt - W_DINT'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/apu_aout_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : apu_aout_sequencer
// Purpose : Timing sequencer for the audio-out 16x oversampling path. Drives
//           the FIR step/shift strobes, pulls one mixer sample per OSR ticks
//           over valid/ready, flags underruns and marks fresh filter output.
// Ports   : clk, rst_n                 - clock, async active-low reset
//           cfg_en                     - run enable
//           cfg_div_int/cfg_div_frac   - clocks per tick (int.frac)
//           s_valid/s_ready/s_data     - mixer sample handshake
//           filt_en/filt_en_shift      - filter step / sample-shift strobes
//           filt_d                     - sample presented to the filter
//           out_valid                  - filter q updated on previous edge
//           phase                      - current oversample phase
//           underrun/underrun_clr      - sticky underrun flag and its clear
// Revision: 1.0 - initial release
// ============================================================================
module apu_aout_sequencer
    import apu_aout_sequencer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_en,
    input  logic [W_DINT-1:0]          cfg_div_int,
    input  logic [W_DFRAC-1:0]         cfg_div_frac,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [W_SAMPLE-1:0] s_data,
    output logic                       filt_en,
    output logic                       filt_en_shift,
    output logic signed [W_SAMPLE-1:0] filt_d,
    output logic                       out_valid,
    output logic [W_PHASE-1:0]         phase,
    output logic                       underrun,
    input  logic                       underrun_clr
);

    logic               w_en;
    logic               w_tick;
    logic               w_shift;
    logic [W_PHASE-1:0] r_phase;
    logic               r_out_valid;
    logic               r_underrun;

    // Gating with rst_n keeps the combinational strobes low while reset is
    // held, even if cfg_en is already high and the counter sits at 0.
    assign w_en = cfg_en & rst_n;

    apu_frac_clkdiv u_clkdiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (w_en),
        .div_int  (cfg_div_int),
        .div_frac (cfg_div_frac),
        .tick     (w_tick)
    );

    // The sample slot is the tick at phase 0; s_ready deliberately ignores
    // s_valid so the mixer cannot create a combinational loop.
    assign w_shift       = w_tick && (r_phase == '0);
    assign filt_en       = w_tick;
    assign filt_en_shift = w_shift;
    assign s_ready       = w_shift;
    assign filt_d        = (w_shift && s_valid) ? s_data : '0;
    assign phase         = r_phase;
    assign out_valid     = r_out_valid;
    assign underrun      = r_underrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= '0;
            r_out_valid <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_out_valid <= w_tick;
            // OSR is a power of two, so natural wrap gives mod OSR.
            if (!w_en) begin
                r_phase <= '0;
            end else if (w_tick) begin
                r_phase <= r_phase + W_PHASE'(1);
            end
            // Set has priority over clear so a coincident underrun is kept.
            if (w_shift && !s_valid) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apu_aout_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_apu_aout_sequencer
// Purpose : Self-checking bench for apu_aout_sequencer: a table of per-cycle
//           vectors plus hand-written multi-cycle sequences.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_apu_aout_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_en;
    logic [7:0]  cfg_div_int;
    logic [7:0]  cfg_div_frac;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        filt_en;
    logic        filt_en_shift;
    logic [15:0] filt_d;
    logic        out_valid;
    logic [3:0]  phase;
    logic        underrun;
    logic        underrun_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apu_aout_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_en        (cfg_en),
        .cfg_div_int   (cfg_div_int),
        .cfg_div_frac  (cfg_div_frac),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .filt_en       (filt_en),
        .filt_en_shift (filt_en_shift),
        .filt_d        (filt_d),
        .out_valid     (out_valid),
        .phase         (phase),
        .underrun      (underrun),
        .underrun_clr  (underrun_clr)
    );

    typedef struct packed {
        logic        en;
        logic [7:0]  di;
        logic [7:0]  df;
        logic        v;
        logic [15:0] d;
        logic        clr;
        logic [24:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [24:0] pk(input logic fe, input logic fs, input logic rd,
                                       input logic [15:0] d, input logic [3:0] ph,
                                       input logic ov, input logic ur);
        return {fe, fs, rd, d, ph, ov, ur};
    endfunction

    function automatic logic [24:0] act();
        return {filt_en, filt_en_shift, s_ready, filt_d, phase, out_valid, underrun};
    endfunction

    function automatic vec_t mk(input logic en, input logic [7:0] di, input logic [7:0] df,
                                input logic v, input logic [15:0] d, input logic clr,
                                input logic [24:0] e);
        vec_t r;
        r = '{en: en, di: di, df: df, v: v, d: d, clr: clr, exp: e};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 4 ns later.
    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [7:0] di, input logic [7:0] df);
        cfg_en = 1'b0;
        underrun_clr = 1'b1;
        cyc_end();
        underrun_clr = 1'b0;
        cfg_div_int  = di;
        cfg_div_frac = df;
        cfg_en       = 1'b1;
    endtask

    initial begin
        int   n;
        int   prev;
        logic exp_fe;
        logic exp_fs;
        logic seen_prev;

        rst_n = 1'b0; cfg_en = 1'b1; cfg_div_int = 8'd2; cfg_div_frac = 8'd0;
        s_valid = 1'b1; s_data = 16'h1234; underrun_clr = 1'b0;
        #3;
        chk("reset_outputs", 32'(act()), 32'(pk(0,0,0,16'h0,0,0,0)));
        @(posedge clk); @(posedge clk); #1;
        cfg_en = 1'b0;
        rst_n  = 1'b1;
        cyc_end();

        // ---------------- table-driven per-cycle vectors -------------------
        //               en di    df     v  data      clr  fe fs rd d        ph ov ur
        vq.push_back(mk(1, 8'd2, 8'h00, 1, 16'h1234, 0, pk(1,1,1,16'h1234,0,0,0)));
        vq.push_back(mk(1, 8'd2, 8'h00, 1, 16'h1234, 0, pk(0,0,0,16'h0000,1,1,0)));
        vq.push_back(mk(1, 8'd2, 8'h00, 1, 16'h1234, 0, pk(1,0,0,16'h0000,1,0,0)));
        vq.push_back(mk(1, 8'd2, 8'h00, 1, 16'h1234, 0, pk(0,0,0,16'h0000,2,1,0)));
        vq.push_back(mk(0, 8'd2, 8'h00, 1, 16'h1234, 0, pk(0,0,0,16'h0000,2,0,0)));
        vq.push_back(mk(1, 8'd2, 8'h00, 0, 16'h1234, 0, pk(1,1,1,16'h0000,0,0,0)));
        vq.push_back(mk(1, 8'd2, 8'h00, 0, 16'h1234, 0, pk(0,0,0,16'h0000,1,1,1)));
        vq.push_back(mk(0, 8'd2, 8'h00, 0, 16'h1234, 1, pk(0,0,0,16'h0000,1,0,1)));
        vq.push_back(mk(1, 8'd0, 8'h00, 0, 16'h1234, 1, pk(1,1,1,16'h0000,0,0,0)));
        vq.push_back(mk(1, 8'd0, 8'h00, 1, 16'h1234, 0, pk(0,0,0,16'h0000,1,1,1)));
        vq.push_back(mk(1, 8'd0, 8'h00, 1, 16'h1234, 0, pk(1,0,0,16'h0000,1,0,1)));
        vq.push_back(mk(1, 8'd1, 8'h00, 1, 16'h1234, 0, pk(0,0,0,16'h0000,2,1,1)));
        vq.push_back(mk(1, 8'd1, 8'h00, 1, 16'h1234, 0, pk(1,0,0,16'h0000,2,0,1)));
        vq.push_back(mk(1, 8'd1, 8'h00, 1, 16'h1234, 0, pk(0,0,0,16'h0000,3,1,1)));
        vq.push_back(mk(0, 8'd3, 8'h80, 1, 16'hBEEF, 0, pk(0,0,0,16'h0000,3,0,1)));
        vq.push_back(mk(1, 8'd3, 8'h80, 1, 16'hBEEF, 0, pk(1,1,1,16'hBEEF,0,0,1)));
        vq.push_back(mk(1, 8'd3, 8'h80, 1, 16'hBEEF, 0, pk(0,0,0,16'h0000,1,1,1)));
        vq.push_back(mk(1, 8'd3, 8'h80, 1, 16'hBEEF, 0, pk(0,0,0,16'h0000,1,0,1)));
        vq.push_back(mk(1, 8'd3, 8'h80, 1, 16'hBEEF, 0, pk(1,0,0,16'h0000,1,0,1)));
        vq.push_back(mk(1, 8'd3, 8'h80, 1, 16'hBEEF, 0, pk(0,0,0,16'h0000,2,1,1)));
        vq.push_back(mk(1, 8'd3, 8'h80, 1, 16'hBEEF, 0, pk(0,0,0,16'h0000,2,0,1)));
        vq.push_back(mk(1, 8'd3, 8'h80, 1, 16'hBEEF, 0, pk(0,0,0,16'h0000,2,0,1)));
        vq.push_back(mk(1, 8'd3, 8'h80, 1, 16'hBEEF, 0, pk(1,0,0,16'h0000,2,0,1)));

        for (int i = 0; i < vq.size(); i++) begin
            cfg_en = vq[i].en; cfg_div_int = vq[i].di; cfg_div_frac = vq[i].df;
            s_valid = vq[i].v; s_data = vq[i].d; underrun_clr = vq[i].clr;
            #4;
            chk($sformatf("vec%0d", i), 32'(act()), 32'(vq[i].exp));
            cyc_end();
        end

        // ---------------- int=4, frac=0: every 4th clk, shift every 64 -----
        s_valid = 1'b1;
        restart(8'd4, 8'd0);
        for (int k = 0; k < 136; k++) begin
            logic [3:0] eph;
            s_data = 16'(k * 7 + 3);
            exp_fe = (k % 4) == 0;
            exp_fs = (k % 64) == 0;
            eph    = 4'(((k + 3) / 4) % 16);
            #4;
            chk($sformatf("div4_k%0d", k),
                {7'd0, filt_en, filt_en_shift, s_ready, filt_d, phase},
                {7'd0, exp_fe, exp_fs, exp_fs, (exp_fs ? s_data : 16'h0), eph});
            cyc_end();
        end

        // ---------------- int=4, frac=0x80: 4,5 alternating; 32 ticks=144 --
        restart(8'd4, 8'h80);
        n = 0; prev = 0;
        for (int k = 0; k <= 200; k++) begin
            #4;
            if (filt_en) begin
                if (n > 0)
                    chk($sformatf("frac_ivl%0d", n), 32'(k - prev), ((n - 1) % 2 == 0) ? 32'd4 : 32'd5);
                if (n % 16 == 0)
                    chk($sformatf("frac_wrap%0d", n), {27'd0, filt_en_shift, phase}, {27'd0, 1'b1, 4'd0});
                if (n == 32) begin
                    chk("frac_32_ticks_clks", 32'(k), 32'd144);
                    break;
                end
                prev = k;
                n++;
            end
            if (k == 200) chk("frac_timeout", 32'(n), 32'd32);
            cyc_end();
        end

        // ---------------- int=1 and int=0 act as int=2 ---------------------
        for (int m = 0; m < 2; m++) begin
            restart((m == 0) ? 8'd1 : 8'd0, 8'd0);
            seen_prev = 1'b0;
            for (int k = 0; k < 20; k++) begin
                #4;
                chk($sformatf("int%0d_k%0d", 1 - m, k), {31'd0, filt_en}, {31'd0, (k % 2) == 0});
                if (seen_prev && filt_en) chk("back_to_back", 32'd1, 32'd0);
                seen_prev = filt_en;
                cyc_end();
            end
        end

        // ---------------- cfg_en dropped mid-interval at phase 7 ------------
        restart(8'd4, 8'd0);
        for (int k = 0; k < 26; k++) cyc_end();
        #4;
        chk("drop_phase7", {28'd0, phase}, {28'd0, 4'd7});
        chk("drop_midivl", {31'd0, filt_en}, 32'd0);
        cyc_end();
        cfg_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #4;
            chk($sformatf("dis_k%0d", k), {29'd0, filt_en, filt_en_shift, s_ready}, 32'd0);
            cyc_end();
        end
        cfg_en = 1'b1; s_data = 16'h5A5A;
        #4;
        chk("reen_first", {7'd0, filt_en, filt_en_shift, s_ready, filt_d, phase},
            {7'd0, 1'b1, 1'b1, 1'b1, 16'h5A5A, 4'd0});
        cyc_end();

        // ---------------- async reset mid-run ------------------------------
        for (int k = 0; k < 6; k++) cyc_end();
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'(act()), 32'(pk(0,0,0,16'h0,0,0,0)));
        s_valid = 1'b1; s_data = 16'h0F0F;
        cyc_end();
        rst_n = 1'b1;
        #4;
        chk("post_reset_first", 32'(act()), 32'(pk(1,1,1,16'h0F0F,0,0,0)));
        cyc_end();
        #4;
        chk("post_reset_second", 32'(act()), 32'(pk(0,0,0,16'h0,1,1,0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
